rom_download_writer: RTL
========================

Name: rom_download_writer

Overview:
- Sits between the mist_io ioctl download port and the SDRAM controller's write port. It replaces the ad-hoc combinational boot write path.
- Maps the ROM image stream (ioctl_index 0) into the fixed SDRAM ROM slots for both model banks.
- Buffers bytes in a small FIFO so that ioctl writes never depend on SDRAM slot timing. Each write is held until the SDRAM accepts it on a clkref slot.
- Reports busy, done, error, byte count and checksum to the top level. busy holds the system reset during loading.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 23, SDRAM byte address width.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download active
- ioctl_index  in  8  download index; only 0 is handled
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte offset in the image
- ioctl_dout  in  8  byte data
- clkref  in  1  SDRAM slot strobe; a write is accepted when mem_we & clkref
- mem_we  out  1  write request
- mem_addr  out  AW  SDRAM address
- mem_bank  out  1  model bank
- mem_din  out  8  write data
- busy  out  1  load in progress or FIFO not yet drained
- done  out  1  one-cycle pulse when the load has completed
- error  out  1  sticky: out-of-range offset or FIFO overflow
- byte_count  out  18  bytes accepted in the current load
- checksum  out  16  mod-2^16 sum of accepted bytes

Behaviour:
- Reset (async): FIFO emptied, state IDLE, and every output is 0.
- active = ioctl_download & (ioctl_index == 0).
- Slot map, k = ioctl_addr[24:14]:
  - k = 0 or 4 -> addr[22:14] = 9'h000
  - k = 1 or 5 -> 9'h100
  - k = 2 or 6 -> 9'h107
  - k = 3 or 7 -> 9'h1FF
  - addr[13:0] = ioctl_addr[13:0]
  - bank = 1 for k = 4..7, otherwise 0.
- k > 7: the byte is dropped and error is set.
- Push happens when active & ioctl_wr & k ≤ 7 & (fill < DEPTH | pop this cycle).
  - A push against a full FIFO with no pop is dropped and sets error.
  - A push increments byte_count (saturating at 2^18−1) and adds ioctl_dout to checksum.
  - Pushed entries are registered, so a write request becomes visible one cycle after ioctl_wr at the earliest.
- Output side:
  - mem_we = FIFO not empty.
  - mem_addr, mem_bank and mem_din show the head entry and stay stable while mem_we is high.
  - The head is popped on the cycle mem_we & clkref is true; the next entry appears on the following cycle.
  - Simultaneous push and pop: fill is unchanged and order is preserved.
- State machine:
  - IDLE: a rising edge of active -> LOAD. byte_count, checksum and error are cleared.
  - LOAD: a falling edge of active -> DRAIN.
  - DRAIN: FIFO empty -> DONE. A rising edge of active -> LOAD (counters are cleared, FIFO contents are kept and drained).
  - DONE: one cycle, done = 1, then -> IDLE.
- busy = 1 in LOAD and DRAIN, 0 in IDLE and DONE.
- ioctl_wr outside LOAD, or with ioctl_index ≠ 0, is ignored.
- byte_count, checksum and error keep their values after DONE until the next load starts.
- Reset asserted mid-load aborts immediately: any pending FIFO data is discarded and mem_we drops asynchronously.

Test Plan:
- Download index 0, 16 bytes 0x01..0x10 at offset 0, clkref every 16 cycles:
  - -> 16 writes to addr 0x000000..0x00000F, bank 0, in order.
  - -> byte_count 16, checksum 0x0088.
  - -> one done pulse after the last acceptance, busy low afterwards.
- Bytes at offsets 0x04000, 0x0C123 and 0x1C123:
  - -> addr 0x400000, bank 0.
  - -> addr 0x7FC123, bank 0.
  - -> addr 0x7FC123, bank 1.
- Byte at offset 0x20000 (k = 8):
  - -> no write, error = 1, byte_count unchanged.
- DEPTH = 4, clkref held low, 5 consecutive ioctl_wr:
  - -> 4 entries buffered, fifth dropped, error = 1.
  - -> raise clkref -> exactly 4 writes.
- Push on the same cycle as a pop with the FIFO full:
  - -> accepted, no error, order intact.
- ioctl_download with index 1:
  - -> no writes, busy stays 0.
- Reset during LOAD with 3 entries pending:
  - -> mem_we 0 immediately, all outputs 0.
  - -> no writes after release.

Source files
------------

// File: rtl/rom_download_writer.sv
// Buffers mist_io ROM download bytes (index 0) into the fixed SDRAM ROM slots of both
// model banks, holding each write until the SDRAM controller accepts it on a clkref slot.
module rom_download_writer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 23
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          clkref,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          mem_bank,
    output logic [7:0]    mem_din,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [17:0]   byte_count,
    output logic [15:0]   checksum
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW = PW + 1;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            clear_c;
    logic            active_c;
    logic            active_q;
    logic            rise_c;
    logic            fall_c;
    logic [10:0]     slot_k_c;
    logic [8:0]      slot_c;
    logic            in_range_c;
    entry_t          wr_entry_c;
    logic            pop_c;
    logic            full_c;
    logic            wr_req_c;
    logic            push_c;
    logic            err_c;
    entry_t          fifo [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_inc_c;
    logic [FW-1:0]   fill;

    assign active_c = ioctl_download & (ioctl_index == 8'd0);
    assign rise_c   = active_c & ~active_q;
    assign fall_c   = ~active_c & active_q;

    // Image offset to SDRAM slot; both banks share the same four slot bases.
    always_comb begin
        slot_c     = 9'h000;
        slot_k_c   = ioctl_addr[24:14];
        in_range_c = (slot_k_c[10:3] == 8'd0);
        case (slot_k_c[1:0])
            2'd0:    slot_c = 9'h000;
            2'd1:    slot_c = 9'h100;
            2'd2:    slot_c = 9'h107;
            default: slot_c = 9'h1FF;
        endcase
        wr_entry_c.bank = slot_k_c[2];
        wr_entry_c.addr = AW'({slot_c, ioctl_addr[13:0]});
        wr_entry_c.data = ioctl_dout;
    end

    assign pop_c    = mem_we & clkref;
    assign full_c   = (fill == FW'(DEPTH));
    assign wr_req_c = (state == S_LOAD) & active_c & ioctl_wr;
    assign push_c   = wr_req_c & in_range_c & (~full_c | pop_c);
    assign err_c    = wr_req_c & (~in_range_c | (full_c & ~pop_c));
    assign rd_inc_c = rd_ptr + PW'(1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
        end else begin
            active_q <= active_c;
        end
    end

    // Storage array carries no reset; validity is tracked by fill.
    always_ff @(posedge clk_sys) begin
        if (push_c) begin
            fifo[wr_ptr] <= wr_entry_c;
        end
    end

    // Pointers, fill level and the registered head entry presented to the SDRAM.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_bank <= 1'b0;
            mem_din  <= 8'd0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_inc_c;
            end
            case ({push_c, pop_c})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            if (pop_c) begin
                if (fill > FW'(1)) begin
                    mem_we   <= 1'b1;
                    mem_bank <= fifo[rd_inc_c].bank;
                    mem_addr <= fifo[rd_inc_c].addr;
                    mem_din  <= fifo[rd_inc_c].data;
                end else if (push_c) begin
                    mem_we   <= 1'b1;
                    mem_bank <= wr_entry_c.bank;
                    mem_addr <= wr_entry_c.addr;
                    mem_din  <= wr_entry_c.data;
                end else begin
                    mem_we <= 1'b0;
                end
            end else if ((fill == '0) && push_c) begin
                mem_we   <= 1'b1;
                mem_bank <= wr_entry_c.bank;
                mem_addr <= wr_entry_c.addr;
                mem_din  <= wr_entry_c.data;
            end
        end
    end

    // Load statistics, cleared whenever a new load starts.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            byte_count <= 18'd0;
            checksum   <= 16'd0;
            error      <= 1'b0;
        end else if (clear_c) begin
            byte_count <= 18'd0;
            checksum   <= 16'd0;
            error      <= 1'b0;
        end else begin
            if (push_c) begin
                if (byte_count != '1) begin
                    byte_count <= byte_count + 18'd1;
                end
                checksum <= checksum + {8'd0, ioctl_dout};
            end
            if (err_c) begin
                error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_LOAD) || (state_next == S_DRAIN);
            done  <= (state_next == S_DONE);
        end
    end

    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise_c) begin
                    state_next = S_LOAD;
                    clear_c    = 1'b1;
                end
            end
            S_LOAD: begin
                if (fall_c) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rise_c) begin
                    state_next = S_LOAD;
                    clear_c    = 1'b1;
                end else if (fill == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
